// File: rtl/rr_decode_scheduler.sv
// Round-robin scheduler: grants one of DECODE_WIDTH requesters at a time,
// holds the grant until the requester drops it or MAX_HOLD cycles elapse,
// and publishes the winner as an encoded index and a one-hot vector.
module rr_decode_scheduler #(
  parameter int unsigned ENCODE_WIDTH = 4,
  parameter int unsigned DECODE_WIDTH = 1 << ENCODE_WIDTH,
  parameter int unsigned MAX_HOLD     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DECODE_WIDTH-1:0] req,
  output logic                    grant_valid,
  output logic [ENCODE_WIDTH-1:0] grant_idx,
  output logic [DECODE_WIDTH-1:0] grant_onehot,
  output logic [7:0]              hold_cnt
);

  localparam int unsigned HOLD_WIDTH = 8;
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                  state, state_n;
  logic                    valid_n;
  logic [ENCODE_WIDTH-1:0] idx_n;
  logic [DECODE_WIDTH-1:0] onehot_n;
  logic [HOLD_WIDTH-1:0]   hold_n;
  logic [ENCODE_WIDTH-1:0] ptr, ptr_n;

  logic                    cur_req;
  logic                    timeout;
  logic                    release_grant;
  logic [DECODE_WIDTH-1:0] cand;
  logic [ENCODE_WIDTH-1:0] after_cur;

  // First set bit of v scanning start, start+1, ... with wrap-around
  function automatic logic [ENCODE_WIDTH-1:0] rr_pick(
    input logic [DECODE_WIDTH-1:0] v,
    input logic [ENCODE_WIDTH-1:0] start
  );
    logic [ENCODE_WIDTH-1:0] pick;
    logic [ENCODE_WIDTH-1:0] idx;
    logic                    found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      idx = start + ENCODE_WIDTH'(i);
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Release detection for the current holder
  always_comb begin
    cur_req       = req[grant_idx];
    timeout       = (hold_cnt == HOLD_LAST);
    release_grant = !cur_req || timeout;
    cand          = req & ~(DECODE_WIDTH'(1) << grant_idx);
    after_cur     = grant_idx + ENCODE_WIDTH'(1);
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    valid_n = grant_valid;
    idx_n   = grant_idx;
    hold_n  = hold_cnt;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        idx_n   = '0;
        hold_n  = '0;
        if (en && (|req)) begin
          state_n = GRANT;
          valid_n = 1'b1;
          idx_n   = rr_pick(req, ptr);
        end
      end
      GRANT: begin
        if (!release_grant) begin
          hold_n = hold_cnt + HOLD_WIDTH'(1);
        end else begin
          ptr_n  = after_cur;
          hold_n = '0;
          if (en && (|cand)) begin
            idx_n = rr_pick(cand, after_cur);
          end else if (en && cur_req) begin
            // Sole requester timed out: re-grant the same index
            idx_n = grant_idx;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            idx_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        idx_n   = '0;
        hold_n  = '0;
      end
    endcase
    onehot_n = valid_n ? (DECODE_WIDTH'(1) << idx_n) : '0;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      hold_cnt     <= '0;
      ptr          <= '0;
    end else begin
      state        <= state_n;
      grant_valid  <= valid_n;
      grant_idx    <= idx_n;
      grant_onehot <= onehot_n;
      hold_cnt     <= hold_n;
      ptr          <= ptr_n;
    end
  end

endmodule

// File: tb/tb_rr_decode_scheduler.sv
// Self-checking bench for rr_decode_scheduler: directed sequences, a vector
// table, a MAX_HOLD=1 instance, and random traffic against a reference model.
module tb_rr_decode_scheduler;

  localparam int D = 16;
  localparam int MH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] req = '0;

  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_onehot;
  logic [7:0]  hold_cnt;

  logic        v1;
  logic [3:0]  i1;
  logic [15:0] o1;
  logic [7:0]  h1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rr_decode_scheduler #(.ENCODE_WIDTH(4), .DECODE_WIDTH(16), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .grant_onehot(grant_onehot), .hold_cnt(hold_cnt)
  );

  rr_decode_scheduler #(.ENCODE_WIDTH(4), .DECODE_WIDTH(16), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .grant_valid(v1), .grant_idx(i1), .grant_onehot(o1), .hold_cnt(h1)
  );

  // Reference model: who holds the resource, for how long, where the scan starts
  typedef struct packed {
    logic       v;
    logic [3:0] idx;
    logic [7:0] hold;
    logic [3:0] ptr;
  } mstate_t;

  mstate_t m;

  function automatic int first_from(logic [15:0] v, int p);
    for (int i = 0; i < D; i++) begin
      if (v[(p + i) % D]) return (p + i) % D;
    end
    return 0;
  endfunction

  function automatic mstate_t model_next(mstate_t s, logic e, logic [15:0] r);
    mstate_t n;
    logic [15:0] c;
    int k;
    n = s;
    k = int'(s.idx);
    if (!s.v) begin
      if (e && r != 0) begin
        n.v    = 1'b1;
        n.idx  = 4'(first_from(r, int'(s.ptr)));
        n.hold = 8'd0;
      end
    end else if (r[k] && int'(s.hold) != MH - 1) begin
      n.hold = s.hold + 8'd1;
    end else begin
      n.ptr  = 4'((k + 1) % D);
      n.hold = 8'd0;
      c = r;
      c[k] = 1'b0;
      if (e && c != 0) n.idx = 4'(first_from(c, (k + 1) % D));
      else if (!(e && r[k])) begin
        n.v   = 1'b0;
        n.idx = 4'd0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, en, req);
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk(input string tag, input logic ev, input int ei, input int eh);
    logic [15:0] eo;
    eo = ev ? (16'd1 << ei) : 16'd0;
    cmp({tag, "_valid"},  32'(grant_valid),  32'(ev));
    cmp({tag, "_idx"},    32'(grant_idx),    ev ? 32'(ei) : 32'd0);
    cmp({tag, "_onehot"}, 32'(grant_onehot), 32'(eo));
    cmp({tag, "_hold"},   32'(hold_cnt),     ev ? 32'(eh) : 32'd0);
  endtask

  task automatic step(input logic e, input logic [15:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        en;
    logic [15:0] req;
    logic        ev;
    int          ei;
    int          eh;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 16'h0008, 1'b1, 3, 0};
    tbl[1] = '{1'b0, 16'h00F8, 1'b1, 3, 1};
    tbl[2] = '{1'b0, 16'h00F8, 1'b1, 3, 2};
    tbl[3] = '{1'b0, 16'h00F0, 1'b0, 0, 0};
    tbl[4] = '{1'b0, 16'h00F0, 1'b0, 0, 0};
    tbl[5] = '{1'b1, 16'h00F0, 1'b1, 4, 0};
    tbl[6] = '{1'b1, 16'h00F0, 1'b1, 4, 1};
    tbl[7] = '{1'b1, 16'h00E0, 1'b1, 5, 0};
    tbl[8] = '{1'b1, 16'h0000, 1'b0, 0, 0};

    // Reset state and single grant/drop
    @(posedge clk);
    #1;
    chk("reset", 1'b0, 0, 0);
    rst = 1'b0;
    step(1'b1, 16'h0001);
    chk("t1_grant", 1'b1, 0, 0);
    step(1'b1, 16'h0000);
    chk("t1_drop", 1'b0, 0, 0);

    // Two requesters alternate on timeout with no bubble
    do_reset();
    step(1'b1, 16'h8001);
    for (int r = 0; r < 3; r++) begin
      for (int h = 0; h < MH; h++) begin
        chk($sformatf("t2_r%0d_h%0d", r, h), 1'b1, (r % 2 == 1) ? 15 : 0, h);
        if (!(r == 2 && h == MH - 1)) step(1'b1, 16'h8001);
      end
    end
    step(1'b1, 16'h0000);
    chk("t2_idle", 1'b0, 0, 0);

    // Single-bit walk, pointer wraps back to 0
    do_reset();
    for (int i = 0; i < D; i++) begin
      step(1'b1, 16'd1 << i);
      chk($sformatf("t3_walk%0d", i), 1'b1, i, 0);
      step(1'b1, 16'h0000);
      chk($sformatf("t3_rel%0d", i), 1'b0, 0, 0);
    end
    step(1'b1, 16'h8001);
    chk("t3_wrap", 1'b1, 0, 0);
    step(1'b1, 16'h0000);

    // Sole requester re-granted on timeout
    do_reset();
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 16'h0010);
      chk($sformatf("t4_c%0d", n), 1'b1, 4, n % MH);
    end
    step(1'b1, 16'h0000);
    chk("t4_idle", 1'b0, 0, 0);

    // en=0 lets current grant finish, then idles; table-driven
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].req);
      chk($sformatf("t5_v%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].eh);
    end

    // Async reset mid-grant clears outputs and pointer
    do_reset();
    for (int n = 0; n < 6; n++) step(1'b1, 16'h0200);
    chk("t6_pre", 1'b1, 9, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async", 1'b0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 16'h0201);
    chk("t6_ptr0", 1'b1, 0, 0);

    // MAX_HOLD=1 rotates every cycle
    do_reset();
    for (int n = 0; n < 6; n++) begin
      step(1'b1, 16'h0011);
      cmp($sformatf("mh1_valid%0d", n), 32'(v1), 32'd1);
      cmp($sformatf("mh1_idx%0d", n),   32'(i1), (n % 2 == 0) ? 32'd0 : 32'd4);
      cmp($sformatf("mh1_oh%0d", n),    32'(o1), (n % 2 == 0) ? 32'h0001 : 32'h0010);
      cmp($sformatf("mh1_hold%0d", n),  32'(h1), 32'd0);
    end

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] r;
      logic        e;
      r = req;
      case ($urandom_range(0, 3))
        0: r = 16'($urandom) & 16'($urandom);
        1: r[$urandom_range(0, 15)] = ~r[$urandom_range(0, 15)];
        default: ;
      endcase
      e = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step(e, r);
      rst = 1'b0;
      chk($sformatf("rnd%0d", n), m.v, int'(m.idx), int'(m.hold));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rr_decode_scheduler.md
Name: rr_decode_scheduler

Overview:
- Round-robin scheduler that shares one select-line resource among 2^ENCODE_WIDTH requesters.
- Picks one requester and holds the grant until that requester releases it or a hold-timeout expires.
- Publishes the winner as an encoded index (drives the one-hot decoder) and as a registered one-hot grant vector.
- Sits between requesting agents and the decoder-driven select bus.

Parameters:
ENCODE_WIDTH, 4, width of encoded grant index.
DECODE_WIDTH, 1 << ENCODE_WIDTH, number of requesters / one-hot grant width; must equal 2^ENCODE_WIDTH.
MAX_HOLD, 8, maximum consecutive cycles one grant may be held; legal range 1 to 255.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
en  input  1  arbitration enable; gates new grants only.
req  input  DECODE_WIDTH  request vector, bit k = requester k.
grant_valid  output  1  a grant is active this cycle.
grant_idx  output  ENCODE_WIDTH  encoded winner; feeds decoder input.
grant_onehot  output  DECODE_WIDTH  registered one-hot grant.
hold_cnt  output  8  cycles the current grant has been held, 0-based.

Behaviour:
- Reset (async, immediate, also mid-grant):
  - state=IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, hold_cnt=0.
  - Internal priority pointer ptr=0.
- Invariant: grant_onehot == (1 << grant_idx) when grant_valid=1; grant_onehot == 0 when grant_valid=0. All outputs are registered.
- Winner search: first set bit of the candidate vector, scanning ptr, ptr+1, ..., wrapping DECODE_WIDTH-1 -> 0.
- IDLE state:
  - If en=1 and req!=0, the winner k is registered.
  - Next cycle: state=GRANT, grant_valid=1, grant_idx=k, hold_cnt=0.
  - Latency from req sampled to grant visible is 1 cycle.
  - If en=0 or req==0, stay IDLE with outputs 0.
- GRANT state, current grant k:
  - Each cycle without release: hold_cnt += 1.
  - Release condition: req[k]==0 (drop), or hold_cnt == MAX_HOLD-1 (timeout).
  - On release: ptr <= (k+1) mod DECODE_WIDTH, wrapping 15 -> 0 for the default width.
  - Candidates on release = req with bit k masked off.
  - If candidates != 0 and en=1: the new winner (searched from k+1) is granted next cycle. This is back-to-back with no bubble; hold_cnt=0.
  - If candidates == 0 on timeout, en=1 and req[k]=1: k is re-granted, hold_cnt=0, grant_valid stays 1.
  - Otherwise: IDLE, grant_valid=0 next cycle.
- en=0 during GRANT:
  - The current grant continues until release.
  - Release then goes to IDLE; no re-grant.
- MAX_HOLD=1: release every cycle; the grant rotates each cycle among active requesters.
- hold_cnt never exceeds MAX_HOLD-1.
- Request bits for non-granted requesters may change at any time; only req[k] affects the current grant.
- Simultaneous drop and timeout are treated as a single release, with identical behaviour.

Test Plan:
1. Reset then req=16'h0001, en=1 -> after 1 cycle grant_valid=1, grant_idx=0, grant_onehot=16'h0001; drop req -> next cycle grant_valid=0, onehot=0.
2. req=16'h8001 held constant, MAX_HOLD=8 -> idx0 for 8 cycles (hold_cnt 0..7), then idx15 for 8 cycles, then idx0; no idle cycle between grants.
3. Walk each single req bit i=0..15, one at a time -> grant_onehot == 1<<i and grant_idx == i every time; ptr wraps from 15 to 0 correctly.
4. req=16'h0010 only, held for 20 cycles -> idx4 continuously re-granted; hold_cnt sequence 0..7,0..7,0..3; grant_valid never drops.
5. Grant active on idx3, set en=0 -> grant holds until req[3] drops, then grant_valid=0 even with req=16'h00F0 pending; restore en=1 -> idx4 granted 1 cycle later.
6. Assert rst mid-grant (idx9, hold_cnt=5) -> all outputs 0 immediately without waiting for a clock edge; after release with req=16'h0201 -> idx0 wins, since ptr was reset to 0.
